// File: rtl/arm_lp_pkg.sv
// Shared ISA constants for the ARM-LP core: instruction classes, opType codes and ALU codes.
// The control decoder, ALU and datapath all import this package.
package arm_lp_pkg;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_R    = 3'd1;
    localparam logic [2:0] OP_I    = 3'd2;
    localparam logic [2:0] OP_D    = 3'd3;
    localparam logic [2:0] OP_B    = 3'd4;
    localparam logic [2:0] OP_CB   = 3'd5;
    localparam logic [2:0] OP_IW   = 3'd6;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_CBZ  = 4'd7;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_SUB  = 4'd10;
    localparam logic [3:0] ALU_NAND = 4'd12;
    localparam logic [3:0] ALU_MOV  = 4'd13;

    // Class field values found in instruction[29:26].
    localparam logic [3:0] CLS_R     = 4'b0010;
    localparam logic [3:0] CLS_STORE = 4'b0110;
    localparam logic [3:0] CLS_B     = 4'b0001;
    localparam logic [3:0] CLS_CB    = 4'b1001;
    localparam logic [3:0] CLS_IGRP  = 4'b0100;

    // I-group sub-select in instruction[23:22]; 2'b11 is illegal.
    localparam logic [1:0] ISUB_ARITH = 2'b00;
    localparam logic [1:0] ISUB_LOAD  = 2'b01;
    localparam logic [1:0] ISUB_MOV   = 2'b10;

    // Only func 0-7 are legal; the caller rejects func[3] = 1.
    function automatic logic [3:0] rFuncToAlu(input logic [2:0] func);
        case (func)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SUB;
            3'd2:    return ALU_AND;
            3'd3:    return ALU_OR;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_NOR;
            3'd6:    return ALU_NAND;
            default: return ALU_MOV;
        endcase
    endfunction

    function automatic logic [3:0] iFuncToAlu(input logic [1:0] func);
        case (func)
            2'd0:    return ALU_ADD;
            2'd1:    return ALU_SUB;
            2'd2:    return ALU_AND;
            default: return ALU_OR;
        endcase
    endfunction

endpackage

// File: rtl/arm_lp_main_decoder.sv
// Combinational instruction -> control mapping for the ARM-LP core.
// Anything not recognised decodes to an all-zero NOP.
module arm_lp_main_decoder
    import arm_lp_pkg::*;
(
    input  logic [31:0] instruction,
    output logic        regWrite,
    output logic [2:0]  opType,
    output logic        memWrite,
    output logic        memRead,
    output logic [3:0]  aluControl,
    output logic        branch,
    output logic        uncondBranch,
    output logic        aluSrc
);

    logic [3:0] instrClass;
    logic       unusedBits;

    assign instrClass = instruction[29:26];
    // Bits [31:30] and the operand fields carry no control information.
    assign unusedBits = ^{instruction[31:30], instruction[21:0]};

    always_comb begin
        regWrite     = 1'b0;
        opType       = OP_NONE;
        memWrite     = 1'b0;
        memRead      = 1'b0;
        aluControl   = ALU_NONE;
        branch       = 1'b0;
        uncondBranch = 1'b0;
        aluSrc       = 1'b0;
        case (instrClass)
            CLS_R: begin
                if (!instruction[25]) begin
                    regWrite   = 1'b1;
                    opType     = OP_R;
                    aluControl = rFuncToAlu(instruction[24:22]);
                end
            end
            CLS_STORE: begin
                memWrite   = 1'b1;
                aluSrc     = 1'b1;
                aluControl = ALU_ADD;
                opType     = OP_D;
            end
            CLS_B: begin
                uncondBranch = 1'b1;
                opType       = OP_B;
            end
            CLS_CB: begin
                branch     = 1'b1;
                aluControl = ALU_CBZ;
                opType     = OP_CB;
            end
            CLS_IGRP: begin
                case (instruction[23:22])
                    ISUB_ARITH: begin
                        regWrite   = 1'b1;
                        aluSrc     = 1'b1;
                        aluControl = iFuncToAlu(instruction[25:24]);
                        opType     = OP_I;
                    end
                    ISUB_LOAD: begin
                        regWrite   = 1'b1;
                        memRead    = 1'b1;
                        aluSrc     = 1'b1;
                        aluControl = ALU_ADD;
                        opType     = OP_D;
                    end
                    ISUB_MOV: begin
                        regWrite   = 1'b1;
                        aluSrc     = 1'b1;
                        aluControl = ALU_MOV;
                        opType     = OP_IW;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arm_lp_ctrl_decoder.sv
// ARM-LP main control unit: combinational decode followed by one register stage,
// so every control output appears one cycle after the instruction is sampled.
module arm_lp_ctrl_decoder
    import arm_lp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic        regWriteFlag,
    output logic [2:0]  opType,
    output logic        memWriteFlag,
    output logic        memReadFlag,
    output logic [3:0]  aluControlCode,
    output logic        branchFlag,
    output logic        unconditionalBranchFlag,
    output logic        aluSRC
);

    logic       regWriteP0;
    logic [2:0] opTypeP0;
    logic       memWriteP0;
    logic       memReadP0;
    logic [3:0] aluControlP0;
    logic       branchP0;
    logic       uncondBranchP0;
    logic       aluSrcP0;

    arm_lp_main_decoder uDecoder (
        .instruction (instruction),
        .regWrite    (regWriteP0),
        .opType      (opTypeP0),
        .memWrite    (memWriteP0),
        .memRead     (memReadP0),
        .aluControl  (aluControlP0),
        .branch      (branchP0),
        .uncondBranch(uncondBranchP0),
        .aluSrc      (aluSrcP0)
    );

    // Stage p0 -> p1: every control output is a flop, all updated together.
    always_ff @(posedge clk) begin
        if (reset) begin
            regWriteFlag            <= 1'b0;
            opType                  <= OP_NONE;
            memWriteFlag            <= 1'b0;
            memReadFlag             <= 1'b0;
            aluControlCode          <= ALU_NONE;
            branchFlag              <= 1'b0;
            unconditionalBranchFlag <= 1'b0;
            aluSRC                  <= 1'b0;
        end else begin
            regWriteFlag            <= regWriteP0;
            opType                  <= opTypeP0;
            memWriteFlag            <= memWriteP0;
            memReadFlag             <= memReadP0;
            aluControlCode          <= aluControlP0;
            branchFlag              <= branchP0;
            unconditionalBranchFlag <= uncondBranchP0;
            aluSRC                  <= aluSrcP0;
        end
    end

endmodule

// File: tb/tb_arm_lp_ctrl_decoder.sv
// Scoreboard bench for arm_lp_ctrl_decoder: the driver queues hand-computed expectations,
// the monitor compares them against the registered outputs one cycle later.
module tb_arm_lp_ctrl_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        regWriteFlag;
    logic [2:0]  opType;
    logic        memWriteFlag;
    logic        memReadFlag;
    logic [3:0]  aluControlCode;
    logic        branchFlag;
    logic        unconditionalBranchFlag;
    logic        aluSRC;

    int testsRun = 0;
    int testsFailed = 0;

    // Packed as {regWrite, opType[2:0], memWrite, memRead, alu[3:0], branch, uBranch, aluSRC}.
    logic [12:0] expQ[$];
    string       nameQ[$];

    arm_lp_ctrl_decoder dut (
        .clk                    (clk),
        .reset                  (reset),
        .instruction            (instruction),
        .regWriteFlag           (regWriteFlag),
        .opType                 (opType),
        .memWriteFlag           (memWriteFlag),
        .memReadFlag            (memReadFlag),
        .aluControlCode         (aluControlCode),
        .branchFlag             (branchFlag),
        .unconditionalBranchFlag(unconditionalBranchFlag),
        .aluSRC                 (aluSRC)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] pack(input logic rw, input logic [2:0] op, input logic mw,
                                         input logic mr, input logic [3:0] alu, input logic br,
                                         input logic ub, input logic src);
        return {rw, op, mw, mr, alu, br, ub, src};
    endfunction

    task automatic drive(input string name, input logic rst, input logic [31:0] instr,
                         input logic [12:0] expected);
        @(negedge clk);
        reset = rst;
        instruction = instr;
        expQ.push_back(expected);
        nameQ.push_back(name);
    endtask

    // Monitor: outputs are registered, so each edge presents the response to the previous drive.
    always @(posedge clk) begin
        logic [12:0] act;
        logic [12:0] exp;
        string       nm;
        #1;
        if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            nm  = nameQ.pop_front();
            act = {regWriteFlag, opType, memWriteFlag, memReadFlag, aluControlCode,
                   branchFlag, unconditionalBranchFlag, aluSRC};
            testsRun++;
            if (act !== exp) begin
                testsFailed++;
                $display("FAIL %s: got rw=%b op=%0d mw=%b mr=%b alu=%0d br=%b ub=%b src=%b, want rw=%b op=%0d mw=%b mr=%b alu=%0d br=%b ub=%b src=%b",
                         nm, act[12], act[11:9], act[8], act[7], act[6:3], act[2], act[1], act[0],
                         exp[12], exp[11:9], exp[8], exp[7], exp[6:3], exp[2], exp[1], exp[0]);
            end
            testsRun++;
            if ((memReadFlag && memWriteFlag) || (branchFlag && unconditionalBranchFlag)) begin
                testsFailed++;
                $display("FAIL %s_exclusive: got mr=%b mw=%b br=%b ub=%b, want no pair both 1",
                         nm, memReadFlag, memWriteFlag, branchFlag, unconditionalBranchFlag);
            end
        end
    end

    initial begin
        logic [12:0] zero;
        int waitCycles;
        zero = '0;
        reset = 1'b1;
        instruction = 32'h0800_0000;

        drive("reset_r",     1'b1, 32'h0800_0000, zero);
        drive("reset_hold",  1'b1, 32'h1040_0000, zero);
        drive("load",        1'b0, 32'h1040_0000, pack(1, 3'd3, 0, 1, 4'd2,  0, 0, 1));
        drive("store",       1'b0, 32'h1800_0000, pack(0, 3'd3, 1, 0, 4'd2,  0, 0, 1));
        drive("r_add",       1'b0, 32'h0800_0000, pack(1, 3'd1, 0, 0, 4'd2,  0, 0, 0));
        drive("r_sub",       1'b0, 32'h0840_0000, pack(1, 3'd1, 0, 0, 4'd10, 0, 0, 0));
        drive("r_nand",      1'b0, 32'h0980_0000, pack(1, 3'd1, 0, 0, 4'd12, 0, 0, 0));
        drive("r_mov_hi30",  1'b0, 32'hC9C0_0000, pack(1, 3'd1, 0, 0, 4'd13, 0, 0, 0));
        drive("i_add",       1'b0, 32'h1000_0000, pack(1, 3'd2, 0, 0, 4'd2,  0, 0, 1));
        drive("i_or",        1'b0, 32'h1300_0000, pack(1, 3'd2, 0, 0, 4'd4,  0, 0, 1));
        drive("b",           1'b0, 32'h0400_0000, pack(0, 3'd4, 0, 0, 4'd0,  0, 1, 0));
        drive("cb",          1'b0, 32'h2400_0000, pack(0, 3'd5, 0, 0, 4'd7,  1, 0, 0));
        drive("mov",         1'b0, 32'h1080_0000, pack(1, 3'd6, 0, 0, 4'd13, 0, 0, 1));
        drive("illegal_isub",1'b0, 32'h10C0_0000, zero);
        drive("illegal_func",1'b0, 32'h0A00_0000, zero);
        drive("illegal_cls", 1'b0, 32'h3C00_0000, zero);
        drive("r_xor",       1'b0, 32'h0900_0000, pack(1, 3'd1, 0, 0, 4'd9,  0, 0, 0));
        drive("mid_reset",   1'b1, 32'h1040_0000, zero);
        drive("post_load",   1'b0, 32'h1040_0000, pack(1, 3'd3, 0, 1, 4'd2,  0, 0, 1));
        drive("post_cb",     1'b0, 32'h2400_0000, pack(0, 3'd5, 0, 0, 4'd7,  1, 0, 0));

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        #2;
        if (expQ.size() > 0) begin
            testsRun++;
            testsFailed++;
            $display("FAIL drain_timeout: got %0d pending, want 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
